// File: rtl/cpu_pkg.sv
// Shared register-file geometry and writeback types for the CPU core.
package cpu_pkg;
  localparam int REG_AW       = 5;
  localparam int DATA_W       = 32;
  localparam int NUM_REGS     = 32;
  localparam int MAX_WAIT_DEF = 3;
  // Starvation counter width; MAX_WAIT is limited to 15
  localparam int CNT_W        = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One register-file write as it leaves the arbiter
  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-result scoreboard for multicycle mult/div destinations.
// A bit is set at issue and cleared when the mult/div result is accepted.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  input  reg_addr_t           rs_addr,
  input  reg_addr_t           rt_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic                conflict
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                conflict_q, conflict_d;

  // Next busy vector: retire first, then issue, so a same-cycle issue wins
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Flag an issue to a register whose earlier result is still outstanding
  always_comb begin
    conflict_d = set_en && (set_addr != '0) && busy_q[set_addr] &&
                 !(clr_en && clr_addr == set_addr);
  end

  // Scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy     = busy_q;
  assign conflict = conflict_q;
  // Hazard query reads registered state only; a retirement this cycle is not bypassed
  assign rs_busy  = busy_q[rs_addr];
  assign rt_busy  = busy_q[rt_addr];

endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the
// multicycle mult/div unit is forced through after MAX_WAIT denied cycles.
module regwrite_arbiter
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                WbValid,
  output logic                WbReady,
  input  logic [REG_AW-1:0]   WbAddr,
  input  logic [DATA_W-1:0]   WbData,
  input  logic                MdValid,
  output logic                MdReady,
  input  logic [REG_AW-1:0]   MdAddr,
  input  logic [DATA_W-1:0]   MdData,
  input  logic                IssueValid,
  input  logic [REG_AW-1:0]   IssueAddr,
  input  logic [REG_AW-1:0]   RsAddr,
  input  logic [REG_AW-1:0]   RtAddr,
  output logic                RsBusy,
  output logic                RtBusy,
  output logic [NUM_REGS-1:0] Busy,
  output logic                RegWrite,
  output logic [REG_AW-1:0]   RdAddr,
  output logic [DATA_W-1:0]   RdData,
  output logic                IssueConflict
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  wr_req_t          wr_q, wr_d;
  logic             md_gnt, wb_gnt;

  // Grant: Wb by default, Md when Wb idle or Md has been starved long enough
  always_comb begin
    md_gnt = !Reset && MdValid && (!WbValid || cnt_q == WAIT_LIM);
    wb_gnt = !Reset && WbValid && !md_gnt;
  end

  assign WbReady = wb_gnt;
  assign MdReady = md_gnt;

  // Starvation counter: counts denied Md cycles, saturating at the limit
  always_comb begin
    cnt_d = '0;
    if (MdValid && !md_gnt)
      cnt_d = (cnt_q == WAIT_LIM) ? cnt_q : cnt_q + 1'b1;
  end

  // Register-file write capture; r0 transfers are accepted but never written
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    if (wb_gnt) begin
      wr_d.we   = (WbAddr != '0);
      wr_d.addr = WbAddr;
      wr_d.data = WbData;
    end else if (md_gnt) begin
      wr_d.we   = (MdAddr != '0);
      wr_d.addr = MdAddr;
      wr_d.data = MdData;
    end
  end

  // Arbiter state and registered write port
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      wr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
    end
  end

  assign RegWrite = wr_q.we;
  assign RdAddr   = wr_q.addr;
  assign RdData   = wr_q.data;

  reg_scoreboard u_sb (
    .clk      (Clock),
    .rst      (Reset),
    .set_en   (IssueValid),
    .set_addr (IssueAddr),
    .clr_en   (md_gnt),
    .clr_addr (MdAddr),
    .rs_addr  (RsAddr),
    .rt_addr  (RtAddr),
    .busy     (Busy),
    .rs_busy  (RsBusy),
    .rt_busy  (RtBusy),
    .conflict (IssueConflict)
  );

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: stimulus pushes expected writes,
// a monitor pops them whenever the DUT presents RegWrite.
module tb_regwrite_arbiter;
  import cpu_pkg::*;

  localparam int MW = 3;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        WbValid, WbReady, MdValid, MdReady;
  logic [4:0]  WbAddr, MdAddr, IssueAddr, RsAddr, RtAddr, RdAddr;
  logic [31:0] WbData, MdData, RdData, Busy;
  logic        IssueValid, RsBusy, RtBusy, RegWrite, IssueConflict;

  always #5 Clock = ~Clock;

  regwrite_arbiter #(.MAX_WAIT(MW)) dut (
    .Clock(Clock), .Reset(Reset),
    .WbValid(WbValid), .WbReady(WbReady), .WbAddr(WbAddr), .WbData(WbData),
    .MdValid(MdValid), .MdReady(MdReady), .MdAddr(MdAddr), .MdData(MdData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RsBusy(RsBusy), .RtBusy(RtBusy),
    .Busy(Busy), .RegWrite(RegWrite), .RdAddr(RdAddr), .RdData(RdData),
    .IssueConflict(IssueConflict)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          total = 0, bad = 0, cyc = 0;
  // Reference state: pending registers, and how long Md has been refused
  logic [31:0] m_busy = '0;
  int          m_denied = 0;
  bit          m_wb_acc = 0, m_md_acc = 0;

  task automatic chk1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write must match the oldest expected one
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset) begin
      if (RegWrite) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got r%0d=%0h want none", RdAddr, RdData);
        end else begin
          e = q.pop_front();
          chk32("wr_cycle", cyc, e.cyc);
          chk32("wr_addr", {27'd0, RdAddr}, {27'd0, e.addr});
          chk32("wr_data", RdData, e.data);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        total++; bad++;
        $display("FAIL missing_write: got none want r%0d=%0h", q[0].addr, q[0].data);
        e = q.pop_front();
      end
    end
  end

  // One clock: inputs already driven; check combinational outputs, advance model
  task automatic step();
    bit md_ok, wb_ok, conf;
    #1;
    md_ok = MdValid && (!WbValid || m_denied == MW);
    wb_ok = WbValid && !md_ok;
    chk1("wb_ready", WbReady, wb_ok);
    chk1("md_ready", MdReady, md_ok);
    chk32("busy", Busy, m_busy);
    chk1("rs_busy", RsBusy, m_busy[RsAddr]);
    chk1("rt_busy", RtBusy, m_busy[RtAddr]);
    @(posedge Clock);
    if (wb_ok && WbAddr != 0) q.push_back('{cyc + 1, WbAddr, WbData});
    if (md_ok && MdAddr != 0) q.push_back('{cyc + 1, MdAddr, MdData});
    conf = IssueValid && IssueAddr != 0 && m_busy[IssueAddr] &&
           !(md_ok && MdAddr == IssueAddr);
    if (md_ok) m_busy[MdAddr] = 1'b0;
    if (IssueValid) m_busy[IssueAddr] = 1'b1;
    m_busy[0] = 1'b0;
    if (MdValid && !md_ok) m_denied = (m_denied < MW) ? m_denied + 1 : MW;
    else m_denied = 0;
    m_wb_acc = wb_ok;
    m_md_acc = md_ok;
    cyc++;
    @(negedge Clock);
    chk1("issue_conflict", IssueConflict, conf);
  endtask

  task automatic idle();
    WbValid = 0; MdValid = 0; IssueValid = 0;
  endtask

  initial begin
    int md_cyc, denied_seen;
    bit wb_at3;
    int idx[$];

    Reset = 1; idle();
    WbAddr = 0; WbData = 0; MdAddr = 0; MdData = 0;
    IssueAddr = 0; RsAddr = 0; RtAddr = 0;
    #22;
    chk1("rst_regwrite", RegWrite, 1'b0);
    chk32("rst_busy", Busy, 32'd0);
    chk1("rst_wbready", WbReady, 1'b0);
    @(negedge Clock);
    Reset = 0;

    // Wb-only write
    WbValid = 1; WbAddr = 5; WbData = 32'hDEADBEEF;
    step();
    idle();
    chk1("t34_regwrite", RegWrite, 1'b1);
    chk32("t34_rdaddr", {27'd0, RdAddr}, 32'd5);
    chk32("t34_rddata", RdData, 32'hDEADBEEF);
    step();

    // Contention: Md forced through on the fourth cycle
    md_cyc = -1; wb_at3 = 1;
    MdValid = 1; MdAddr = 9; MdData = 32'h0000_9999;
    for (int c = 0; c < 6; c++) begin
      WbValid = 1; WbAddr = 5'(c + 1); WbData = $urandom;
      step();
      if (m_md_acc) begin md_cyc = c; MdValid = 0; end
      if (c == 3) wb_at3 = m_wb_acc;
    end
    idle();
    chk32("t35_md_grant_cycle", md_cyc, 32'd3);
    chk1("t35_wb_denied_at3", wb_at3, 1'b0);
    step(); step();

    // Scoreboard set and retire of r7
    IssueValid = 1; IssueAddr = 7; RsAddr = 7; RtAddr = 0;
    step();
    IssueValid = 0;
    #1 chk1("t36_rsbusy_set", RsBusy, 1'b1);
    MdValid = 1; MdAddr = 7; MdData = 32'h77;
    step();
    MdValid = 0;
    #1 chk1("t36_rsbusy_clr", RsBusy, 1'b0);
    step();

    // Same-cycle issue/retire of r12, then a genuine conflict
    IssueValid = 1; IssueAddr = 12;
    step();
    MdValid = 1; MdAddr = 12; MdData = 32'h1212;
    step();
    MdValid = 0;
    chk1("t37_busy12_kept", Busy[12], 1'b1);
    chk1("t37_no_conflict", IssueConflict, 1'b0);
    step();
    IssueValid = 0;
    chk1("t37_conflict_pulse", IssueConflict, 1'b1);
    MdValid = 1;
    step();
    MdValid = 0;
    chk1("t37_conflict_gone", IssueConflict, 1'b0);
    step();

    // r0: accepted but never written, never busy
    WbValid = 1; WbAddr = 0; WbData = 32'hFFFF_0000;
    IssueValid = 1; IssueAddr = 0;
    step();
    idle();
    chk1("t38_no_regwrite", RegWrite, 1'b0);
    chk32("t38_busy_zero", Busy, 32'd0);
    step();

    // Reset in the middle of contention
    IssueValid = 1; IssueAddr = 3;
    step();
    IssueValid = 0;
    MdValid = 1; MdAddr = 3; MdData = 32'h3333;
    for (int c = 0; c < 2; c++) begin
      WbValid = 1; WbAddr = 2; WbData = $urandom;
      step();
    end
    chk32("t39_busy3_before", Busy, 32'h8);
    #2 Reset = 1;
    #1;
    chk1("t39_regwrite", RegWrite, 1'b0);
    chk32("t39_rdaddr", {27'd0, RdAddr}, 32'd0);
    chk32("t39_rddata", RdData, 32'd0);
    chk32("t39_busy", Busy, 32'd0);
    chk1("t39_conflict", IssueConflict, 1'b0);
    chk1("t39_wbready", WbReady, 1'b0);
    chk1("t39_mdready", MdReady, 1'b0);
    m_busy = '0; m_denied = 0; q.delete();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 0;
    denied_seen = 0;
    for (int c = 0; c < 10 && MdValid; c++) begin
      WbValid = 1; WbAddr = 2; WbData = $urandom;
      step();
      if (m_md_acc) MdValid = 0;
      else denied_seen++;
    end
    idle();
    chk32("t39_denied_after_reset", denied_seen, 32'd3);
    step();

    // Random traffic with handshake-stable requesters
    for (int n = 0; n < 600; n++) begin
      if (!(WbValid && !m_wb_acc)) begin
        WbValid = ($urandom_range(9) < 6);
        WbAddr  = 5'($urandom);
        WbData  = $urandom;
      end
      if (!(MdValid && !m_md_acc)) begin
        MdValid = ($urandom_range(9) < 4);
        MdAddr  = 5'($urandom);
        MdData  = $urandom;
        idx.delete();
        for (int i = 1; i < 32; i++) if (m_busy[i]) idx.push_back(i);
        if (idx.size() > 0 && $urandom_range(3) != 0)
          MdAddr = 5'(idx[$urandom_range(idx.size() - 1)]);
      end
      IssueValid = ($urandom_range(4) == 0);
      IssueAddr  = 5'($urandom);
      RsAddr     = 5'($urandom);
      RtAddr     = 5'($urandom);
      step();
    end
    idle();
    step(); step(); step();
    chk32("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
